// File: rtl/hello_pkg.sv
// ---------------------------------------------------------------------------
// hello_pkg
// Shared types and constants for the scrolling HELLO character source.
//   char_t       3-bit character code driven into the display register chain
//   CH_*         character codes (H, E, L, O, BLANK)
//   src_state_t  states of the character source controller
//   MSG_ROM      the eight-character message, index 0 emitted first
// ---------------------------------------------------------------------------
package hello_pkg;

  typedef logic [2:0] char_t;

  localparam char_t CH_H     = 3'd0;
  localparam char_t CH_E     = 3'd1;
  localparam char_t CH_L     = 3'd2;
  localparam char_t CH_O     = 3'd3;
  localparam char_t CH_BLANK = 3'd7;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } src_state_t;

  localparam char_t MSG_ROM [8] = '{CH_H, CH_E, CH_L, CH_L, CH_O,
                                    CH_BLANK, CH_BLANK, CH_BLANK};

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous input, followed by a registered
// rising-edge detector.
//   CLOCK_50  in   system clock
//   KEY       in   asynchronous active-low reset
//   din       in   asynchronous input (switch or pushbutton)
//   level     out  synchronized level, two cycles behind din
//   pulse     out  one-cycle pulse, three cycles after a rising edge of din
// ---------------------------------------------------------------------------
module sync_edge (
  input  logic CLOCK_50,
  input  logic KEY,
  input  logic din,
  output logic level,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

  assign level = sync;

endmodule

// File: rtl/hello_char_source.sv
// ---------------------------------------------------------------------------
// hello_char_source
// Character source for the scrolling HELLO display. Emits one character code
// per scroll step together with a one-cycle shift-enable that clocks the
// downstream eight-stage register chain as an enable.
//
// After reset the chain is flushed with eight BLANKs, then the message scrolls
// every TICK_DIV cycles while run is high. run low freezes the display; with
// the HELLO_STEP_EN macro defined, each press of step advances one character
// while paused. Without HELLO_STEP_EN the step port is accepted but ignored.
//
// Parameters
//   TICK_DIV   CLOCK_50 cycles per scroll step, 2 .. 2**26
//   MSG_LEN    message length, only 8 is supported
// Ports
//   CLOCK_50   in   system clock
//   KEY        in   asynchronous active-low reset
//   run        in   asynchronous switch, 1 = auto-scroll, 0 = paused
//   step       in   asynchronous pushbutton, active-high single step
//   char_code  out  character code for the first chain stage (reset BLANK)
//   char_valid out  one-cycle shift-enable for the chain (reset 0)
//   msg_pos    out  message index of the next character to emit (reset 0)
// ---------------------------------------------------------------------------
module hello_char_source
  import hello_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned MSG_LEN  = 8
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic       run,
  input  logic       step,
  output char_t      char_code,
  output logic       char_valid,
  output logic [2:0] msg_pos
);

  localparam int          CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST   = CW'(TICK_DIV - 1);
  localparam logic [2:0]  POS_LAST = 3'(MSG_LEN - 1);

  // ---------------- input conditioning ----------------
  logic run_s;
  logic run_rise_unused;
  logic step_pulse;

  sync_edge u_run_sync (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .din      (run),
    .level    (run_s),
    .pulse    (run_rise_unused)
  );

`ifdef HELLO_STEP_EN
  logic step_level_unused;

  sync_edge u_step_sync (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .din      (step),
    .level    (step_level_unused),
    .pulse    (step_pulse)
  );
`else
  logic step_unused;

  assign step_unused = step;
  assign step_pulse  = 1'b0;
`endif

  // ---------------- controller ----------------
  src_state_t    state;
  src_state_t    state_next;
  logic [2:0]    flush_cnt;
  logic [CW-1:0] count;
  logic          tick;
  logic          emit_blank;
  logic          emit_char;

  // count only moves in RUN, so tick can only fire there
  assign tick = (count == LAST);

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state <= FLUSH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FLUSH:   if (flush_cnt == 3'd7) state_next = run_s ? RUN : PAUSED;
      RUN:     if (!run_s)            state_next = PAUSED;
      PAUSED:  if (run_s)             state_next = RUN;
      default:                        state_next = FLUSH;
    endcase
  end

  // A tick coinciding with run dropping, and a step pulse coinciding with
  // run returning, are both dropped: the state change wins.
  always_comb begin
    emit_blank = 1'b0;
    emit_char  = 1'b0;
    case (state)
      FLUSH:   emit_blank = 1'b1;
      RUN:     emit_char  = run_s & tick;
      PAUSED:  emit_char  = ~run_s & step_pulse;
      default: ;
    endcase
  end

  // flush counter and scroll prescaler; both sit at 0 outside their state,
  // so re-entering RUN always starts a full TICK_DIV period
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      flush_cnt <= '0;
      count     <= '0;
    end else begin
      flush_cnt <= (state == FLUSH) ? flush_cnt + 3'd1 : 3'd0;
      if (state == RUN && run_s) begin
        count <= tick ? '0 : count + CW'(1);
      end else begin
        count <= '0;
      end
    end
  end

  // registered outputs; char_code holds between emissions
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      char_code  <= CH_BLANK;
      char_valid <= 1'b0;
      msg_pos    <= 3'd0;
    end else begin
      char_valid <= emit_blank | emit_char;
      if (emit_blank) begin
        char_code <= CH_BLANK;
      end else if (emit_char) begin
        char_code <= MSG_ROM[msg_pos];
        msg_pos   <= (msg_pos == POS_LAST) ? 3'd0 : msg_pos + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_hello_char_source.sv
// ---------------------------------------------------------------------------
// tb_hello_char_source
// Bench for hello_char_source with TICK_DIV = 4. Directed scenarios check the
// reset values, the flush burst, the scroll order and spacing, pause, single
// step (HELLO_STEP_EN), the run/tick collision and reset mid-run; a random
// phase compares every cycle against a reference model of the behaviour.
// ---------------------------------------------------------------------------
module tb_hello_char_source;

  localparam int TD = 4;
`ifdef HELLO_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk  = 1'b0;
  logic       key  = 1'b1;
  logic       run  = 1'b0;
  logic       step = 1'b0;
  logic [2:0] char_code;
  logic       char_valid;
  logic [2:0] msg_pos;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hello_char_source #(.TICK_DIV(TD), .MSG_LEN(8)) dut (
    .CLOCK_50   (clk),
    .KEY        (key),
    .run        (run),
    .step       (step),
    .char_code  (char_code),
    .char_valid (char_valid),
    .msg_pos    (msg_pos)
  );

  // ---------------- reference model ----------------
  logic [2:0] rom [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd7, 3'd7, 3'd7};

  int         m_flush_left;  // flush BLANKs still to send
  bit         m_running;     // auto-scroll active
  int         m_age;         // cycles into the current scroll period
  int         m_pos;
  logic [2:0] m_code;
  bit         m_valid;
  bit         run_hist [2];  // run pin value 1 and 2 edges ago
  bit         step_hist [4]; // step pin value 1..4 edges ago

  task automatic model_reset();
    m_flush_left = 8;
    m_running    = 1'b0;
    m_age        = 0;
    m_pos        = 0;
    m_code       = 3'd7;
    m_valid      = 1'b0;
    run_hist     = '{default: 1'b0};
    step_hist    = '{default: 1'b0};
  endtask

  task automatic model_emit();
    m_valid = 1'b1;
    m_code  = rom[m_pos];
    m_pos   = (m_pos + 1) % 8;
  endtask

  // One clock edge of behaviour. The controller sees run two edges late and
  // a step press as a single pulse three edges after the rising edge.
  task automatic model_edge();
    bit run_seen;
    bit press;
    run_seen = run_hist[1];
    press    = step_hist[2] & ~step_hist[3];
    m_valid  = 1'b0;
    if (m_flush_left > 0) begin
      m_valid      = 1'b1;
      m_code       = 3'd7;
      m_flush_left = m_flush_left - 1;
      if (m_flush_left == 0) begin
        m_running = run_seen;
        m_age     = 0;
      end
    end else if (m_running) begin
      if (!run_seen) begin
        m_running = 1'b0;
      end else if (m_age == TD - 1) begin
        model_emit();
        m_age = 0;
      end else begin
        m_age = m_age + 1;
      end
    end else if (run_seen) begin
      m_running = 1'b1;
      m_age     = 0;
    end else if (press && STEP_EN) begin
      model_emit();
    end
    step_hist[3] = step_hist[2];
    step_hist[2] = step_hist[1];
    step_hist[1] = step_hist[0];
    step_hist[0] = step;
    run_hist[1]  = run_hist[0];
    run_hist[0]  = run;
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; returns at the following falling edge, where outputs
  // are sampled and inputs may be changed.
  task automatic cyc();
    @(posedge clk);
    if (!key) model_reset();
    else      model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit run_level);
    key  = 1'b0;
    run  = run_level;
    step = 1'b0;
    repeat (3) cyc();
    key = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    run  = 1'b1;
    #1 key = 1'b0;
    #1;
    total++;
    if ({char_valid, char_code, msg_pos} !== {1'b0, 3'd7, 3'd0}) begin
      bad++;
      $display("FAIL reset_async got v=%b c=%0d p=%0d want v=0 c=7 p=0",
               char_valid, char_code, msg_pos);
    end
    repeat (3) cyc();
    total++;
    if ({char_valid, char_code, msg_pos} !== {1'b0, 3'd7, 3'd0}) begin
      bad++;
      $display("FAIL reset_held got v=%b c=%0d p=%0d want v=0 c=7 p=0",
               char_valid, char_code, msg_pos);
    end
  endtask

  task automatic test_flush_scroll();
    logic [2:0] exp_q[$];
    int         exp_t[$];
    logic [2:0] seq [9] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd7, 3'd7, 3'd7, 3'd0};
    logic [2:0] e;
    int         et;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(seq[i]);
      exp_t.push_back(12 + TD * i);
    end
    key = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      cyc();
      total++;
      if ({char_valid, char_code, msg_pos} !== {m_valid, m_code, 3'(m_pos)}) begin
        bad++;
        $display("FAIL scroll_model c=%0d got v=%b c=%0d p=%0d want v=%b c=%0d p=%0d",
                 c, char_valid, char_code, msg_pos, m_valid, m_code, m_pos);
      end
      if (c <= 8) begin
        total++;
        if ({char_valid, char_code} !== {1'b1, 3'd7}) begin
          bad++;
          $display("FAIL flush_burst c=%0d got v=%b c=%0d want v=1 c=7",
                   c, char_valid, char_code);
        end
      end else if (char_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scroll_extra c=%0d got code=%0d want none", c, char_code);
        end else begin
          e  = exp_q.pop_front();
          et = exp_t.pop_front();
          if (char_code !== e || c != et) begin
            bad++;
            $display("FAIL scroll_seq got code=%0d at c=%0d want code=%0d at c=%0d",
                     char_code, c, e, et);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scroll_missing got %0d left want 0", exp_q.size());
    end
    total++;
    if (msg_pos !== 3'd1) begin
      bad++;
      $display("FAIL scroll_wrap got p=%0d want p=1", msg_pos);
    end
  endtask

  task automatic test_pause();
    int n_run = 0;
    int c     = 0;
    do_reset(1'b1);
    while (n_run < 3 && c < 100) begin
      cyc();
      c++;
      if (c > 8 && char_valid) n_run++;
    end
    total++;
    if (n_run < 3) begin
      bad++;
      $display("FAIL pause_timeout got %0d emissions want 3", n_run);
    end
    run = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++;
      if (char_valid !== 1'b0 ||
          {char_valid, char_code, msg_pos} !== {m_valid, m_code, 3'(m_pos)}) begin
        bad++;
        $display("FAIL pause_quiet i=%0d got v=%b c=%0d p=%0d want v=0 (model c=%0d p=%0d)",
                 i, char_valid, char_code, msg_pos, m_code, m_pos);
      end
    end
    total++;
    if (msg_pos !== 3'd3) begin
      bad++;
      $display("FAIL pause_pos got p=%0d want p=3", msg_pos);
    end
  endtask

  task automatic test_step();
    int         n      = 0;
    int         first  = 0;
    logic [2:0] fcode  = 3'd0;
    int         exp_n  = STEP_EN ? 1 : 0;
    int         exp_c  = STEP_EN ? 4 : 0;
    logic [2:0] exp_p  = STEP_EN ? 3'd4 : 3'd3;
    step = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c == 3) step = 1'b0;
      total++;
      if ({char_valid, char_code, msg_pos} !== {m_valid, m_code, 3'(m_pos)}) begin
        bad++;
        $display("FAIL step_model c=%0d got v=%b c=%0d p=%0d want v=%b c=%0d p=%0d",
                 c, char_valid, char_code, msg_pos, m_valid, m_code, m_pos);
      end
      if (char_valid) begin
        n++;
        if (first == 0) begin
          first = c;
          fcode = char_code;
        end
      end
    end
    total++;
    if (n != exp_n || first != exp_c) begin
      bad++;
      $display("FAIL step_count got n=%0d at c=%0d want n=%0d at c=%0d",
               n, first, exp_n, exp_c);
    end
    if (n > 0) begin
      total++;
      if (fcode !== 3'd2) begin
        bad++;
        $display("FAIL step_code got %0d want 2", fcode);
      end
    end
    total++;
    if (msg_pos !== exp_p) begin
      bad++;
      $display("FAIL step_pos got p=%0d want p=%0d", msg_pos, exp_p);
    end
  endtask

  task automatic test_collision();
    int         n_run = 0;
    int         c     = 0;
    int         first = 0;
    logic [2:0] fcode = 3'd0;
    logic [2:0] p0;
    do_reset(1'b1);
    while (n_run < 2 && c < 100) begin
      cyc();
      c++;
      if (c > 8 && char_valid) n_run++;
    end
    total++;
    if (n_run < 2) begin
      bad++;
      $display("FAIL collide_timeout got %0d emissions want 2", n_run);
    end
    p0 = msg_pos;
    // run pin low here makes the synchronized level fall on the tick cycle
    cyc();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if (char_valid !== 1'b0 || msg_pos !== p0) begin
        bad++;
        $display("FAIL collide_quiet i=%0d got v=%b p=%0d want v=0 p=%0d",
                 i, char_valid, msg_pos, p0);
      end
    end
    run = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      total++;
      if ({char_valid, char_code, msg_pos} !== {m_valid, m_code, 3'(m_pos)}) begin
        bad++;
        $display("FAIL collide_model i=%0d got v=%b c=%0d p=%0d want v=%b c=%0d p=%0d",
                 i, char_valid, char_code, msg_pos, m_valid, m_code, m_pos);
      end
      if (char_valid && first == 0) begin
        first = i;
        fcode = char_code;
      end
    end
    // 2 sync cycles, then a full 4-cycle period from RUN entry, plus the
    // registered output
    total++;
    if (first != 7 || fcode !== rom[p0]) begin
      bad++;
      $display("FAIL collide_resume got code=%0d at c=%0d want code=%0d at c=7",
               fcode, first, rom[p0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_q[$];
    logic [2:0] e;
    int         c = 0;
    do_reset(1'b1);
    while (msg_pos !== 3'd5 && c < 100) begin
      cyc();
      c++;
    end
    total++;
    if (msg_pos !== 3'd5) begin
      bad++;
      $display("FAIL midrst_timeout got p=%0d want p=5", msg_pos);
    end
    cyc();
    #2 key = 1'b0;
    #1;
    total++;
    if ({char_valid, char_code, msg_pos} !== {1'b0, 3'd7, 3'd0}) begin
      bad++;
      $display("FAIL midrst_async got v=%b c=%0d p=%0d want v=0 c=7 p=0",
               char_valid, char_code, msg_pos);
    end
    repeat (2) cyc();
    key = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      total++;
      if ({char_valid, char_code} !== {1'b1, 3'd7}) begin
        bad++;
        $display("FAIL midrst_flush i=%0d got v=%b c=%0d want v=1 c=7",
                 i, char_valid, char_code);
      end
    end
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    for (int i = 0; i < 3 * TD + 2 && exp_q.size() > 0; i++) begin
      cyc();
      if (char_valid) begin
        e = exp_q.pop_front();
        total++;
        if (char_code !== e) begin
          bad++;
          $display("FAIL midrst_seq got code=%0d want %0d", char_code, e);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_missing got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 4) == 0) step = ~step;
      if (key && $urandom_range(0, 499) == 0) key = 1'b0;
      else if (!key && $urandom_range(0, 2) == 0) key = 1'b1;
      cyc();
      total++;
      if ({char_valid, char_code, msg_pos} !== {m_valid, m_code, 3'(m_pos)}) begin
        bad++;
        $display("FAIL random i=%0d got v=%b c=%0d p=%0d want v=%b c=%0d p=%0d",
                 i, char_valid, char_code, msg_pos, m_valid, m_code, m_pos);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_flush_scroll();
    test_pause();
    test_step();
    test_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hello_char_source.md
# hello_char_source

Upstream character source for the scrolling HELLO display. Runs directly on CLOCK_50 and emits one 3-bit character code per scroll step, with a one-cycle shift-enable strobe. The strobe clocks the downstream eight-stage register chain as an enable, replacing a derived clock. An internal prescaler sets the scroll rate, a run/pause control freezes the display, and an optional single-step input advances it one character at a time.

## Interface
- TICK_DIV, 25_000_000: CLOCK_50 cycles per scroll step; legal range 2..2^26.
- MSG_LEN, 8: message length in characters; fixed at 8, no other value supported.
- CLOCK_50  in  1  system clock, 50 MHz.
- KEY  in  1  reset; asynchronous, active-low.
- run  in  1  asynchronous switch level; 1 = auto-scroll, 0 = paused.
- step  in  1  asynchronous pushbutton, active-high; each press advances one character while paused.
- char_code  out  3  character code to the first chain stage; reset value BLANK (3'd7).
- char_valid  out  1  one-cycle shift-enable for the chain; reset value 0.
- msg_pos  out  3  index of the next character to be emitted; reset value 0.

## Operation
- Message ROM, indices 0..7: H, E, L, L, O, BLANK, BLANK, BLANK. Codes: H=0, E=1, L=2, O=3, BLANK=7.
- run and step each pass through a 2-flop synchronizer. step is then rising-edge detected, giving a 1-cycle step_pulse.
- Prescaler: counter 0..TICK_DIV-1, free-running only in state RUN. tick = (count == TICK_DIV-1); count wraps to 0 on tick. Counter is held at 0 in every other state.
- States:
  - FLUSH: entered on reset. Emits BLANK with char_valid=1 on 8 consecutive cycles (flush counter 0..7), then goes to RUN (run_s=1) or PAUSED (run_s=0).
  - RUN: on tick, emit ROM[msg_pos], increment msg_pos mod 8. run_s=0 goes to PAUSED.
  - PAUSED: char_valid=0 except on step_pulse, which emits ROM[msg_pos] and increments msg_pos. run_s=1 goes to RUN with the prescaler starting from 0.
- msg_pos wraps 7→0 with no gap cycle.
- Simultaneous events:
  - tick in the same cycle run_s falls: no emission; the state moves to PAUSED.
  - step_pulse in RUN: ignored.
  - step_pulse in the cycle PAUSED exits to RUN: ignored.
  - step_pulse during FLUSH: ignored.
- Reset mid-operation clears everything immediately (async) and restarts FLUSH after KEY deasserts.

## Timing
- All outputs are registered.
- char_valid and char_code update in the cycle after the tick or step_pulse cycle. char_code holds its value until the next emission.
- Auto-scroll period is exactly TICK_DIV cycles.
- First RUN emission occurs TICK_DIV cycles after entering RUN.
- step latency, pin to char_valid: 4 cycles (2 sync + edge + output register).
- After KEY rises:
  - FLUSH char_valid is high on cycles 1..8.
  - The FLUSH→RUN/PAUSED transition occurs on cycle 9.

## Configuration
- HELLO_STEP_EN defined:
  - Step synchronizer and edge detector are instantiated.
  - step_pulse advances one character in PAUSED.
- HELLO_STEP_EN undefined:
  - The step port remains but is ignored; no synchronizer logic is built.
  - PAUSED emits nothing until run returns.

## Structure
- Package hello_pkg holds:
  - typedef char_t (logic [2:0]) and constants CH_H, CH_E, CH_L, CH_O, CH_BLANK.
  - state enum src_state_t {FLUSH, RUN, PAUSED}.
  - MSG_ROM constant array.
- Sub-module sync_edge: 2-flop synchronizer plus rising-edge detector, same CLOCK_50/KEY. Outputs the synchronized level and a 1-cycle pulse. Used for run (level output) and step (pulse output).

## Test plan
All scenarios use TICK_DIV=4.
- Reset release with run=1 → char_valid high for 8 consecutive cycles with char_code=7, then every 4 cycles emits 0,1,2,2,3,7,7,7,0; msg_pos wraps 7→0.
- run=0 after the third RUN emission → no char_valid for 40 cycles; msg_pos holds at 3.
- Paused, step pulsed high for 3 cycles (HELLO_STEP_EN defined) → exactly one char_valid, 4 cycles after the rising edge, char_code=2; msg_pos→4.
- Same as the previous scenario without HELLO_STEP_EN → no char_valid; msg_pos stays 3.
- run falls in the same cycle as tick → no emission; PAUSED entered. run rises → next emission exactly 4 cycles after RUN re-entry.
- KEY asserted low mid-RUN at msg_pos=5 → outputs immediately 7/0/0. On release, the FLUSH sequence repeats and the next emissions are 0,1,2…
